// File: rtl/dfe_cfg_master.sv
// dfe_cfg_master: burst register master for the DFE coefficient bus.
// Accepts read/write burst commands, buffers write words in a small FIFO and
// drives a two-phase (SETUP/ACCESS) select/strobe bus with registered outputs.
module dfe_cfg_master #(
  parameter int unsigned ADDR_WIDTH  = 7,
  parameter int unsigned PDATA_WIDTH = 32,
  parameter int unsigned COEFF_WIDTH = 20,
  parameter int unsigned COMP        = 4,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [$clog2(COMP)-1:0]       cmd_sel,
  input  logic [ADDR_WIDTH-1:0]         cmd_addr,
  input  logic [6:0]                    cmd_len,
  input  logic                          wdata_valid,
  output logic                          wdata_ready,
  input  logic signed [COEFF_WIDTH-1:0] wdata,
  output logic                          rdata_valid,
  output logic [PDATA_WIDTH-1:0]        rdata,
  output logic                          rdata_last,
  output logic                          MTRANS,
  output logic                          MWRITE,
  output logic [COMP-1:0]               MSELx,
  output logic [ADDR_WIDTH-1:0]         MADDR,
  output logic signed [COEFF_WIDTH-1:0] MWDATA,
  input  logic [PDATA_WIDTH-1:0]        MRDATA,
  output logic                          busy,
  output logic                          done,
  output logic                          wrap_err
);

  localparam int unsigned SEL_W = $clog2(COMP);
  localparam int unsigned LEN_W = 7;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_ACCESS = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]                    state_q, state_d;
  logic                          wr_q, wr_d;
  logic [SEL_W-1:0]              sel_q, sel_d;
  logic [ADDR_WIDTH-1:0]         addr_q, addr_d;
  logic [LEN_W-1:0]              beats_q, beats_d;
  logic                          wrap_q, wrap_d;

  logic [COMP-1:0]               msel_q, msel_d;
  logic                          mtrans_q, mtrans_d;
  logic                          mwrite_q, mwrite_d;
  logic [ADDR_WIDTH-1:0]         maddr_q, maddr_d;
  logic signed [COEFF_WIDTH-1:0] mwdata_q, mwdata_d;
  logic [PDATA_WIDTH-1:0]        rdata_q, rdata_d;
  logic                          rvalid_q, rvalid_d;
  logic                          rlast_q, rlast_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          cready_q, cready_d;
  logic                          wready_q, wready_d;

  logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]              rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic signed [COEFF_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic push, pop, fifo_empty;

  // Next-state, FIFO bookkeeping and registered-output values
  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    beats_d  = beats_q;
    wrap_d   = wrap_q;
    msel_d   = '0;
    mtrans_d = 1'b0;
    mwrite_d = 1'b0;
    maddr_d  = '0;
    mwdata_d = '0;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    rlast_d  = 1'b0;
    pop      = 1'b0;

    fifo_empty = (cnt_q == '0);
    push       = wdata_valid && wready_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          wr_d    = cmd_write;
          sel_d   = cmd_sel;
          addr_d  = cmd_addr;
          beats_d = (cmd_len == '0) ? LEN_W'(1) : cmd_len;
          wrap_d  = 1'b0;
          state_d = (cmd_write && fifo_empty) ? S_WAIT : S_SETUP;
        end
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (!wr_q) begin
          rdata_d  = MRDATA;
          rvalid_d = 1'b1;
          rlast_d  = (beats_q <= LEN_W'(1));
        end
        if (beats_q > LEN_W'(1)) begin
          beats_d = beats_q - LEN_W'(1);
          addr_d  = addr_q + ADDR_WIDTH'(1);
          if (&addr_q) wrap_d = 1'b1;
          state_d = (wr_q && fifo_empty) ? S_WAIT : S_SETUP;
        end else begin
          state_d = S_DONE;
        end
      end
      S_WAIT:  if (!fifo_empty) state_d = S_SETUP;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Bus outputs follow the state being entered; SETUP entry pops the write word
    case (state_d)
      S_SETUP: begin
        msel_d   = COMP'(1) << sel_d;
        mwrite_d = wr_d;
        maddr_d  = addr_d;
        if (wr_d) begin
          mwdata_d = mem_q[rd_ptr_q];
          pop      = 1'b1;
        end
      end
      S_ACCESS: begin
        msel_d   = msel_q;
        mtrans_d = 1'b1;
        mwrite_d = mwrite_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
      end
      default: ;
    endcase

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    wready_d = (cnt_d != CNT_W'(FIFO_DEPTH));
    cready_d = (state_d == S_IDLE);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
  end

  // State, command context, FIFO pointers and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_q     <= 1'b0;
      sel_q    <= '0;
      addr_q   <= '0;
      beats_q  <= '0;
      wrap_q   <= 1'b0;
      msel_q   <= '0;
      mtrans_q <= 1'b0;
      mwrite_q <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cready_q <= 1'b1;
      wready_q <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      beats_q  <= beats_d;
      wrap_q   <= wrap_d;
      msel_q   <= msel_d;
      mtrans_q <= mtrans_d;
      mwrite_q <= mwrite_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cready_q <= cready_d;
      wready_q <= wready_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Write-word storage; contents are don't-care while the count is zero
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign cmd_ready   = cready_q;
  assign wdata_ready = wready_q;
  assign rdata_valid = rvalid_q;
  assign rdata       = rdata_q;
  assign rdata_last  = rlast_q;
  assign MTRANS      = mtrans_q;
  assign MWRITE      = mwrite_q;
  assign MSELx       = msel_q;
  assign MADDR       = maddr_q;
  assign MWDATA      = mwdata_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign wrap_err    = wrap_q;

endmodule

// File: tb/tb_dfe_cfg_master.sv
// tb_dfe_cfg_master: scoreboard bench for dfe_cfg_master with directed and random bursts.
module tb_dfe_cfg_master;

  typedef struct packed {
    logic [3:0] sel;
    logic       wr;
    logic [6:0] addr;
  } beat_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } rd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [1:0] cmd_sel = '0;
  logic [6:0] cmd_addr = '0, cmd_len = '0;
  logic wdata_valid = 1'b0;
  logic signed [19:0] wdata = '0;
  logic cmd_ready, wdata_ready, rdata_valid, rdata_last;
  logic [31:0] rdata, MRDATA;
  logic MTRANS, MWRITE, busy, done, wrap_err;
  logic [3:0] MSELx;
  logic [6:0] MADDR;
  logic signed [19:0] MWDATA;

  dfe_cfg_master dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata(rdata), .rdata_last(rdata_last),
    .MTRANS(MTRANS), .MWRITE(MWRITE), .MSELx(MSELx), .MADDR(MADDR),
    .MWDATA(MWDATA), .MRDATA(MRDATA), .busy(busy), .done(done), .wrap_err(wrap_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;
  int cyc = 0, last_done_cyc = -1;
  int push_req = 0;
  bit push_rand = 0;

  beat_t beat_q[$];
  rd_t   rd_q[$];
  logic  done_q[$];
  logic signed [19:0] words_q[$];
  logic [31:0] rmem [4][128];

  function automatic int sel_idx(input logic [3:0] s);
    int r = 0;
    for (int i = 0; i < 4; i++) if (s[i]) r = i;
    return r;
  endfunction

  // Target register file model answering reads
  assign MRDATA = rmem[sel_idx(MSELx)][MADDR];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Write-word driver: directed requests or random traffic; model records accepted words
  always @(negedge clk) begin
    if (push_req > 0 || (push_rand && $urandom_range(0, 1) == 1)) begin
      wdata_valid = 1'b1;
      wdata = 20'($urandom);
      if (wdata_ready === 1'b1) begin
        words_q.push_back(wdata);
        if (push_req > 0) push_req--;
      end
    end else begin
      wdata_valid = 1'b0;
    end
  end

  logic p_trans = 1'b0, p_write = 1'b0;
  logic [3:0] p_sel = '0;
  logic [6:0] p_addr = '0;
  logic signed [19:0] p_wdata = '0;
  beat_t m_eb;
  rd_t m_er;
  logic signed [19:0] m_ew;
  logic m_wrap;

  // Monitor: compares every bus beat, read return and done pulse against the queues
  always @(negedge clk) begin
    if (MTRANS === 1'b1) begin
      check("setup_before_access",
            !p_trans && p_sel == MSELx && p_addr == MADDR && p_write == MWRITE && p_wdata == MWDATA,
            {p_trans, p_sel, p_addr}, {1'b0, MSELx, MADDR});
      if (beat_q.size() == 0) begin
        check("unexpected_beat", 1'b0, {MSELx, MADDR}, 0);
      end else begin
        m_eb = beat_q.pop_front();
        check("beat_sel", MSELx == m_eb.sel, MSELx, m_eb.sel);
        check("beat_addr", MADDR == m_eb.addr, MADDR, m_eb.addr);
        check("beat_write", MWRITE == m_eb.wr, MWRITE, m_eb.wr);
        if (m_eb.wr) begin
          if (words_q.size() == 0) check("beat_wdata_no_word", 1'b0, MWDATA, 0);
          else begin
            m_ew = words_q.pop_front();
            check("beat_wdata", MWDATA == m_ew, MWDATA, m_ew);
          end
        end
      end
    end
    if (rdata_valid === 1'b1) begin
      if (rd_q.size() == 0) check("unexpected_rdata", 1'b0, rdata, 0);
      else begin
        m_er = rd_q.pop_front();
        check("rdata", rdata == m_er.data, rdata, m_er.data);
        check("rdata_last", rdata_last == m_er.last, rdata_last, m_er.last);
      end
    end
    if (done === 1'b1) begin
      last_done_cyc = cyc;
      if (done_q.size() == 0) check("unexpected_done", 1'b0, 1, 0);
      else begin
        m_wrap = done_q.pop_front();
        check("done_wrap_err", wrap_err == m_wrap, wrap_err, m_wrap);
      end
    end
    if (cmd_ready === 1'b1)
      check("idle_bus_zero", {MTRANS, MWRITE, MSELx, MADDR, MWDATA} == '0,
            {MTRANS, MWRITE, MSELx, MADDR, MWDATA}, 0);
    p_trans = MTRANS; p_write = MWRITE; p_sel = MSELx; p_addr = MADDR; p_wdata = MWDATA;
  end

  // Offer a command at a falling edge; returns at the falling edge after acceptance
  task automatic issue(input bit w, input int sel, input int addr, input int len, output int k);
    int l;
    bit got;
    l = (len == 0) ? 1 : len;
    got = 0;
    k = -1;
    cmd_valid = 1'b1; cmd_write = w; cmd_sel = 2'(sel); cmd_addr = 7'(addr); cmd_len = 7'(len);
    for (int t = 0; t < 400; t++) begin
      if (cmd_ready === 1'b1) begin got = 1; break; end
      @(negedge clk);
    end
    check("cmd_accept_timeout", got, {63'd0, cmd_ready}, 1);
    if (!got) begin cmd_valid = 1'b0; return; end
    for (int i = 0; i < l; i++) begin
      beat_q.push_back('{sel: 4'(1) << sel, wr: w, addr: 7'((addr + i) % 128)});
      if (!w) rd_q.push_back('{data: rmem[sel][(addr + i) % 128], last: (i == l - 1)});
    end
    done_q.push_back(addr + l - 1 > 127);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    k = cyc;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1 && busy === 1'b0) begin ok = 1; break; end
    end
    check(name, ok, {63'd0, busy}, 0);
  endtask

  task automatic wait_pushes(input string name);
    for (int t = 0; t < 200 && push_req != 0; t++) @(negedge clk);
    check(name, push_req == 0, push_req, 0);
    @(negedge clk);
  endtask

  int k, seen;
  bit hit;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < 4; s++)
      for (int a = 0; a < 128; a++) rmem[s][a] = $urandom;
    rmem[2][5] = 32'hA5A5_0001;
    rmem[2][6] = 32'hA5A5_0002;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_cmd_ready", cmd_ready == 1'b1, cmd_ready, 1);
    check("rst_wdata_ready", wdata_ready == 1'b1, wdata_ready, 1);
    check("rst_flags", {busy, done, rdata_valid, rdata_last, wrap_err} == '0,
          {busy, done, rdata_valid, rdata_last, wrap_err}, 0);
    check("rst_bus", {MTRANS, MWRITE, MSELx, MADDR, MWDATA, rdata} == '0,
          {MTRANS, MSELx, MADDR}, 0);

    // Three-beat write with preloaded words, latency check
    push_req = 3;
    wait_pushes("preload3");
    issue(1, 1, 8'h10, 3, k);
    check("w3_setup_sel", MSELx == 4'b0010 && !MTRANS && MADDR == 7'h10 && MWRITE,
          {MTRANS, MSELx, MADDR}, {1'b0, 4'b0010, 7'h10});
    check("w3_busy", busy == 1'b1 && cmd_ready == 1'b0, {busy, cmd_ready}, 2'b10);
    @(negedge clk);
    check("w3_access_k2", MTRANS == 1'b1, MTRANS, 1);
    wait_idle("w3_idle");
    check("w3_done_latency", last_done_cyc == k + 6, last_done_cyc, k + 6);

    // Two-beat read
    issue(0, 2, 5, 2, k);
    wait_idle("r2_idle");
    check("r2_all_returned", rd_q.size() == 0, rd_q.size(), 0);

    // Write with empty FIFO stalls in WAIT_DATA with the bus idle
    issue(1, 3, 8'h20, 2, k);
    for (int i = 0; i < 4; i++) begin
      check("wait1_bus_idle", !MTRANS && MSELx == 0 && busy, {MTRANS, MSELx, busy}, 1);
      @(negedge clk);
    end
    push_req = 1;
    hit = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (MTRANS === 1'b1) begin hit = 1; break; end
    end
    check("wait1_beat1_issued", hit, {63'd0, hit}, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("wait2_bus_idle", !MTRANS && MSELx == 0 && busy, {MTRANS, MSELx, busy}, 1);
    end
    push_req = 1;
    wait_idle("wait_idle_end");

    // Address wrap
    push_req = 2;
    wait_pushes("preload_wrap");
    issue(1, 0, 8'h7F, 2, k);
    wait_idle("wrap_idle");
    repeat (3) @(negedge clk);
    check("wrap_sticky", wrap_err == 1'b1, wrap_err, 1);
    issue(0, 1, 0, 1, k);
    check("wrap_cleared_on_accept", wrap_err == 1'b0, wrap_err, 0);
    wait_idle("wrap_read_idle");

    // FIFO full, refill on pop, len=0 single beat
    push_req = 8;
    wait_pushes("fill8");
    check("full_wready_low", wdata_ready == 1'b0, wdata_ready, 0);
    push_req = 1;
    repeat (3) @(negedge clk);
    check("full_no_push", wdata_ready == 1'b0 && push_req == 1, {wdata_ready, 8'(push_req)}, 1);
    issue(1, 1, 8'h30, 0, k);
    wait_idle("len0_idle");
    repeat (2) @(negedge clk);
    check("refilled_full", wdata_ready == 1'b0 && push_req == 0, {wdata_ready, 8'(push_req)}, 0);
    issue(1, 3, 8'h50, 8, k);
    wait_idle("drain_idle");
    check("drained_wready", wdata_ready == 1'b1, wdata_ready, 1);
    check("drained_model", words_q.size() == 0, words_q.size(), 0);

    // Reset during ACCESS of beat 2 of 4
    push_req = 4;
    wait_pushes("preload_rst");
    issue(1, 2, 8'h40, 4, k);
    seen = 0;
    for (int t = 0; t < 20; t++) begin
      if (MTRANS === 1'b1) seen++;
      if (seen == 2) begin rst = 1'b1; break; end
      @(negedge clk);
    end
    check("rst_reached_beat2", seen == 2, seen, 2);
    @(posedge clk);
    beat_q.delete(); rd_q.delete(); done_q.delete(); words_q.delete();
    @(negedge clk);
    rst = 1'b0;
    check("abort_bus_zero", {MTRANS, MWRITE, MSELx, MADDR, MWDATA} == '0, {MTRANS, MSELx, MADDR}, 0);
    check("abort_ready", cmd_ready == 1'b1 && wdata_ready == 1'b1, {cmd_ready, wdata_ready}, 2'b11);
    check("abort_no_done", done == 1'b0 && busy == 1'b0, {done, busy}, 0);
    issue(1, 1, 8'h60, 1, k);
    for (int i = 0; i < 3; i++) begin
      check("abort_fifo_empty", !MTRANS && busy, {MTRANS, busy}, 1);
      @(negedge clk);
    end
    push_req = 1;
    wait_idle("abort_followup_idle");

    // Random bursts against the model
    push_rand = 1;
    for (int n = 0; n < 30; n++) begin
      int a;
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(124, 127)) : int'($urandom_range(0, 127));
      issue(bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)), a, int'($urandom_range(0, 6)), k);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle("rand_idle");
    push_rand = 0;
    repeat (3) @(negedge clk);

    check("end_beats_drained", beat_q.size() == 0, beat_q.size(), 0);
    check("end_reads_drained", rd_q.size() == 0, rd_q.size(), 0);
    check("end_dones_drained", done_q.size() == 0, done_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
